// File: rtl/csa_load_seq_pkg.sv
// Shared widths, slot count and sequencer states for the csa operand loader.
// csa fixes the slot count; the settle time is a module parameter.
package csa_load_seq_pkg;

  localparam int NUM_OPS = 10;
  localparam int OP_W    = 8;
  localparam int SUM_W   = 12;
  localparam int BUS_W   = NUM_OPS * OP_W;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/csa_load_seq_if.sv
// Operand stream in, result stream out, both valid/ready.
// master is the source/sink side, slave is the sequencer.
interface csa_load_seq_if;
  import csa_load_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             out_co;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_co
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_co
  );

endinterface

// File: rtl/csa_load_seq.sv
// Loads up to ten operand bytes into the csa slots, waits for the
// tree to settle, then holds the captured sum until it is taken.
module csa_load_seq
  import csa_load_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  csa_load_seq_if.slave    io,
  output logic [BUS_W-1:0] op_bus,
  input  logic [SUM_W-1:0] csa_sum,
  input  logic             csa_co,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_END =
    IDX_W'(NUM_OPS - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum_q;
  logic             co_q;
  logic             ovalid_q;
  logic             iready_q;
  logic             acc;
  logic             end_beat;

  always_comb begin
    acc      = io.in_valid & iready_q & ~abort;
    end_beat = io.in_last | (idx == IDX_END);
  end

  assign io.in_ready  = iready_q;
  assign io.out_valid = ovalid_q;
  assign io.out_sum   = sum_q;
  assign io.out_co    = co_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      op_bus   <= '0;
      sum_q    <= '0;
      co_q     <= 1'b0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b0;
      busy     <= 1'b0;
    end else if (abort) begin
      // sum_q is deliberately left alone
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      op_bus   <= '0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b1;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          iready_q <= 1'b1;
          if (acc) begin
            op_bus <= BUS_W'(io.in_data);
            idx    <= IDX_W'(1);
            busy   <= 1'b1;
            if (io.in_last) begin
              state    <= SETTLE;
              cnt      <= CNT_INIT;
              iready_q <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (acc) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              if (idx == IDX_W'(i))
                op_bus[i*OP_W +: OP_W] <= io.in_data;
            end
            idx <= idx + 1'b1;
            if (end_beat) begin
              state    <= SETTLE;
              cnt      <= CNT_INIT;
              iready_q <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            sum_q    <= csa_sum;
            co_q     <= csa_co;
            ovalid_q <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            ovalid_q <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_load_seq.sv
// Directed bench: sequencer plus a behavioural csa (integer sum).
// Expected sums are hand-computed constants.
module tb_csa_load_seq;
  import csa_load_seq_pkg::*;

  localparam int SETTLE = 2;

  logic             clk;
  logic             rst_n;
  logic             abort;
  logic [BUS_W-1:0] op_bus;
  logic [SUM_W-1:0] csa_sum;
  logic             csa_co;
  logic             busy;
  logic [SUM_W:0]   tot;

  int n_tests;
  int n_fail;

  csa_load_seq_if io ();

  csa_load_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort   (abort),
    .io      (io.slave),
    .op_bus  (op_bus),
    .csa_sum (csa_sum),
    .csa_co  (csa_co),
    .busy    (busy)
  );

  always_comb begin
    tot = '0;
    for (int i = 0; i < NUM_OPS; i++)
      tot = tot + (SUM_W+1)'(op_bus[i*OP_W +: OP_W]);
  end
  assign csa_sum = tot[SUM_W-1:0];
  assign csa_co  = tot[SUM_W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_last  = last;
    while (!ok && n < 50) begin
      ok = io.in_ready;
      tick();
      n++;
    end
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    if (!ok) chk("send_timeout", 80'(0), 80'(1));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!io.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!io.out_valid) chk("done_timeout", 80'(0), 80'(1));
  endtask

  task automatic job_const(input logic [7:0] d, output int lat);
    for (int i = 0; i < 10; i++) send(d, i == 9);
    wait_done(lat);
  endtask

  int lat;
  logic [SUM_W-1:0] held;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    abort = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 80'(io.in_ready), 80'(0));
    chk("rst_out_valid", 80'(io.out_valid), 80'(0));
    chk("rst_out_sum", 80'(io.out_sum), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_op_bus", op_bus, 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: ten 0xFF beats
    job_const(8'hFF, lat);
    chk("t1_lat", 80'(lat), 80'(SETTLE));
    chk("t1_sum", 80'(io.out_sum), 80'(2550));
    chk("t1_co", 80'(io.out_co), 80'(0));
    tick();
    chk("t1_drained", 80'(io.out_valid), 80'(0));

    // 2: short job then single beat
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    wait_done(lat);
    chk("t2_sum", 80'(io.out_sum), 80'(6));
    chk("t2_slots_dj", 80'(op_bus[79:24]), 80'(0));
    chk("t2_slots_ac", 80'(op_bus[23:0]), 80'(24'h030201));
    tick();
    send(8'd7, 1'b1);
    wait_done(lat);
    chk("t2_single", 80'(io.out_sum), 80'(7));
    chk("t2_single_bus", op_bus, 80'(7));
    tick();

    // 3: ten beats with no in_last, then an extra beat
    io.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(10 + i), 1'b0);
    io.in_valid = 1'b1;
    io.in_data  = 8'd99;
    for (int i = 0; i < 4; i++) begin
      chk("t3_no_accept", 80'(io.in_ready), 80'(0));
      tick();
    end
    chk("t3_sum", 80'(io.out_sum), 80'(145));
    chk("t3_valid", 80'(io.out_valid), 80'(1));
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    tick();

    // 4: backpressure in DONE
    io.out_ready = 1'b0;
    send(8'd40, 1'b0);
    send(8'd2, 1'b1);
    wait_done(lat);
    held = io.out_sum;
    chk("t4_sum", 80'(held), 80'(42));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 80'(io.out_valid), 80'(1));
      chk("t4_hold_sum", 80'(io.out_sum), 80'(42));
    end
    io.out_ready = 1'b1;
    tick();
    chk("t4_valid_fall", 80'(io.out_valid), 80'(0));
    chk("t4_ready_low", 80'(io.in_ready), 80'(0));
    tick();
    chk("t4_ready_rise", 80'(io.in_ready), 80'(1));

    // 5: abort on the 4th beat
    send(8'd5, 1'b0);
    send(8'd6, 1'b0);
    send(8'd7, 1'b0);
    io.in_valid = 1'b1;
    io.in_data  = 8'd8;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    io.in_valid = 1'b0;
    chk("t5_op_bus", op_bus, 80'(0));
    chk("t5_busy", 80'(busy), 80'(0));
    chk("t5_keep_sum", 80'(io.out_sum), 80'(42));
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_valid", 80'(io.out_valid), 80'(0));
      tick();
    end
    job_const(8'd1, lat);
    chk("t5_sum", 80'(io.out_sum), 80'(10));
    tick();

    // 6: async reset during SETTLE
    send(8'd9, 1'b1);
    chk("t6_busy", 80'(busy), 80'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 80'(io.out_valid), 80'(0));
    chk("t6_sum", 80'(io.out_sum), 80'(0));
    chk("t6_busy0", 80'(busy), 80'(0));
    chk("t6_op_bus", op_bus, 80'(0));
    chk("t6_ready", 80'(io.in_ready), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    job_const(8'hFF, lat);
    chk("t6_rerun_lat", 80'(lat), 80'(SETTLE));
    chk("t6_rerun_sum", 80'(io.out_sum), 80'(2550));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
